// File: rtl/uart_command_decoder_pkg.sv
// Shared definitions for the UART command decoder: FSM state encoding,
// sensor command codes and frame error codes.
package uart_cmd_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_CMD = 3'd1;
    localparam logic [2:0] ST_CHECK    = 3'd2;
    localparam logic [2:0] ST_HOLD     = 3'd3;
    localparam logic [2:0] ST_ERROR    = 3'd4;

    // Command codes understood by the sensor controller
    typedef enum logic [7:0] {
        CMD_STATUS        = 8'h00,
        CMD_TEMPERATURE   = 8'h01,
        CMD_HUMIDITY      = 8'h02,
        CMD_CONT_TEMP_ON  = 8'h03,
        CMD_CONT_HUM_ON   = 8'h04,
        CMD_CONT_TEMP_OFF = 8'h05,
        CMD_CONT_HUM_OFF  = 8'h06
    } cmd_e;

    localparam logic [7:0] CMD_MAX = 8'h06;

    // Frame error codes reported on error_code
    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_BAD_ADDR = 3'd1;
    localparam logic [2:0] ERR_BAD_CMD  = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd3;
    localparam logic [2:0] ERR_OVERRUN  = 3'd4;

    function automatic logic is_valid_cmd(input logic [7:0] code);
        return code <= CMD_MAX;
    endfunction

endpackage

// File: rtl/uart_command_decoder_if.sv
// Bundle between the UART receiver / sensor controller and the command
// decoder. The decoder uses the master modport, the environment the slave.
//
// Handshake: a frame is offered while request_valid is high; address and
// command stay stable until the cycle where request_valid and request_ready
// are both high, which transfers the frame. request_valid never drops before
// that transfer (except on reset).
interface uart_command_decoder_if;
    import uart_cmd_pkg::*;

    logic       has_data;
    logic [7:0] data_received;
    logic       request_valid;
    logic       request_ready;
    logic [7:0] request_address;
    logic [7:0] request_command;
    logic       frame_error;
    logic [2:0] error_code;
    logic [2:0] state_dbg;

    modport master (
        input  has_data,
        input  data_received,
        input  request_ready,
        output request_valid,
        output request_address,
        output request_command,
        output frame_error,
        output error_code,
        output state_dbg
    );

    modport slave (
        output has_data,
        output data_received,
        output request_ready,
        input  request_valid,
        input  request_address,
        input  request_command,
        input  frame_error,
        input  error_code,
        input  state_dbg
    );

endinterface

// File: rtl/uart_command_decoder_inter_byte_timer.sv
// Counts cycles spent waiting for the command byte; only instantiated when
// UART_CMD_TIMEOUT_EN is defined. The counter saturates at its limit.
module inter_byte_timer #(
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [22:0] LAST_COUNT = 23'(TIMEOUT_CYCLES - 1);

    logic [22:0] count;

    // Cycle counter: cleared on entry to the wait, counts while enabled
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != LAST_COUNT)) begin
            count <= count + 23'd1;
        end
    end

    assign expired = enable && (count == LAST_COUNT);

endmodule

// File: rtl/uart_command_decoder.sv
// Assembles 2-byte frames (address, command) from the UART receiver,
// validates them and offers them to the sensor controller.
// Optional inter-byte timeout: define UART_CMD_TIMEOUT_EN.
module uart_command_decoder
    import uart_cmd_pkg::*;
#(
    parameter int NUM_SENSORS    = 32,
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic                   clock,
    input  logic                   reset,
    uart_command_decoder_if.master bus
);

    localparam logic [8:0] ADDR_LIMIT = 9'(NUM_SENSORS);

    logic [2:0] state;
    logic [2:0] next_state;
    logic [7:0] req_addr;
    logic [7:0] req_cmd;
    logic [2:0] err_pend;
    logic [2:0] err_code_q;
    logic       bad_addr;
    logic       bad_cmd;
    logic       overrun;
    logic       timer_expired;
    logic [2:0] cur_code;
    logic       strobe;

`ifdef UART_CMD_TIMEOUT_EN
    inter_byte_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   ((state == ST_IDLE) && bus.has_data),
        .enable  (state == ST_WAIT_CMD),
        .expired (timer_expired)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timer_expired      = 1'b0;
`endif

    assign bad_addr = ({1'b0, req_addr} >= ADDR_LIMIT);
    assign bad_cmd  = !is_valid_cmd(req_cmd);

    // A byte arriving while a frame is being checked, held or rejected is lost
    assign overrun = bus.has_data &&
                     ((state == ST_CHECK) || (state == ST_HOLD) || (state == ST_ERROR));

    // Overrun takes the code when it lands on the ERROR-state strobe
    assign cur_code = overrun ? ERR_OVERRUN : err_pend;
    assign strobe   = !reset && ((state == ST_ERROR) || overrun);

    // Next-state selection
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (bus.has_data) next_state = ST_WAIT_CMD;
            end
            ST_WAIT_CMD: begin
                if (bus.has_data)       next_state = ST_CHECK;
                else if (timer_expired) next_state = ST_ERROR;
            end
            ST_CHECK: begin
                if (bad_addr || bad_cmd) next_state = ST_ERROR;
                else                     next_state = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.request_ready) next_state = ST_IDLE;
            end
            ST_ERROR: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State, frame bytes and error bookkeeping
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            req_addr   <= 8'h00;
            req_cmd    <= 8'h00;
            err_pend   <= ERR_NONE;
            err_code_q <= ERR_NONE;
        end else begin
            state <= next_state;
            if ((state == ST_IDLE) && bus.has_data) begin
                req_addr <= bus.data_received;
            end
            if ((state == ST_WAIT_CMD) && bus.has_data) begin
                req_cmd <= bus.data_received;
            end
            if (state == ST_CHECK) begin
                err_pend <= bad_addr ? ERR_BAD_ADDR : ERR_BAD_CMD;
            end
            if ((state == ST_WAIT_CMD) && !bus.has_data && timer_expired) begin
                err_pend <= ERR_TIMEOUT;
            end
            if (strobe) begin
                err_code_q <= cur_code;
            end
        end
    end

    assign bus.request_valid   = (state == ST_HOLD);
    assign bus.request_address = req_addr;
    assign bus.request_command = req_cmd;
    assign bus.frame_error     = strobe;
    assign bus.error_code      = strobe ? cur_code : err_code_q;
    assign bus.state_dbg       = state;

endmodule

// File: tb/tb_uart_command_decoder.sv
// Directed bench for uart_command_decoder with a request/error scoreboard.
module tb_uart_command_decoder;
    import uart_cmd_pkg::*;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;

    logic [15:0] exp_q[$];
    logic [2:0]  err_q[$];

    uart_command_decoder_if bus ();

    uart_command_decoder #(
        .NUM_SENSORS    (32),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.has_data      = 1'b1;
        bus.data_received = b;
        tick();
        bus.has_data      = 1'b0;
        bus.data_received = $urandom_range(0, 255);
    endtask

    // Scoreboard: compare transfers and error strobes against expectations
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.request_valid && bus.request_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_request", 32'd1, 32'd0);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    chk("req_address", {24'd0, bus.request_address}, {24'd0, e[15:8]});
                    chk("req_command", {24'd0, bus.request_command}, {24'd0, e[7:0]});
                end
            end
            if (bus.frame_error) begin
                if (err_q.size() == 0) begin
                    chk("unexpected_error", {29'd0, bus.error_code}, 32'hFFFF);
                end else begin
                    logic [2:0] c;
                    c = err_q.pop_front();
                    chk("error_code", {29'd0, bus.error_code}, {29'd0, c});
                end
            end
        end
    end

    initial begin
        int n;
        n_checks           = 0;
        n_errors           = 0;
        reset              = 1'b1;
        bus.has_data       = 1'b0;
        bus.data_received  = 8'h00;
        bus.request_ready  = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        chk("rst_valid", {31'd0, bus.request_valid}, 32'd0);
        chk("rst_frame_error", {31'd0, bus.frame_error}, 32'd0);
        chk("rst_address", {24'd0, bus.request_address}, 32'h00);
        chk("rst_command", {24'd0, bus.request_command}, 32'h00);
        chk("rst_error_code", {29'd0, bus.error_code}, {29'd0, ERR_NONE});
        chk("rst_state", {29'd0, bus.state_dbg}, {29'd0, ST_IDLE});

        // 1: basic frame, consumer already ready
        bus.request_ready = 1'b1;
        exp_q.push_back({8'h05, 8'h01});
        send_byte(8'h05);
        send_byte(8'h01);
        chk("t1_valid_n1", {31'd0, bus.request_valid}, 32'd0);
        tick();
        chk("t1_valid_n2", {31'd0, bus.request_valid}, 32'd1);
        chk("t1_address", {24'd0, bus.request_address}, 32'h05);
        chk("t1_command", {24'd0, bus.request_command}, 32'h01);
        tick();
        chk("t1_valid_n3", {31'd0, bus.request_valid}, 32'd0);
        chk("t1_state_idle", {29'd0, bus.state_dbg}, {29'd0, ST_IDLE});

        // 2: back-pressure for 10 cycles with an overrun byte in the middle
        bus.request_ready = 1'b0;
        exp_q.push_back({8'h03, 8'h02});
        send_byte(8'h03);
        send_byte(8'h02);
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("t2_hold_valid", {31'd0, bus.request_valid}, 32'd1);
            chk("t2_hold_address", {24'd0, bus.request_address}, 32'h03);
            chk("t2_hold_command", {24'd0, bus.request_command}, 32'h02);
            if (i == 4) begin
                err_q.push_back(ERR_OVERRUN);
                bus.has_data      = 1'b1;
                bus.data_received = 8'h77;
            end
            tick();
            bus.has_data = 1'b0;
        end
        bus.request_ready = 1'b1;
        chk("t2_valid_last", {31'd0, bus.request_valid}, 32'd1);
        chk("t2_address_last", {24'd0, bus.request_address}, 32'h03);
        tick();
        chk("t2_valid_drop", {31'd0, bus.request_valid}, 32'd0);
        chk("t2_error_code_held", {29'd0, bus.error_code}, {29'd0, ERR_OVERRUN});
        chk("t2_err_q_empty", err_q.size(), 32'd0);

        // 3: bad address (priority over bad command), then bad command
        err_q.push_back(ERR_BAD_ADDR);
        send_byte(8'h20);
        send_byte(8'h09);
        repeat (3) tick();
        chk("t3_code_bad_addr", {29'd0, bus.error_code}, {29'd0, ERR_BAD_ADDR});
        err_q.push_back(ERR_BAD_CMD);
        send_byte(8'h01);
        send_byte(8'h07);
        repeat (3) tick();
        chk("t3_code_bad_cmd", {29'd0, bus.error_code}, {29'd0, ERR_BAD_CMD});
        chk("t3_err_q_empty", err_q.size(), 32'd0);

`ifdef UART_CMD_TIMEOUT_EN
        // 4: inter-byte timeout
        err_q.push_back(ERR_TIMEOUT);
        send_byte(8'h04);
        n = 0;
        while (!bus.frame_error && n < 200) begin
            tick();
            n++;
        end
        chk("t4_timeout_cycles", n, 32'd100);
        tick();
        exp_q.push_back({8'h04, 8'h00});
        send_byte(8'h04);
        send_byte(8'h00);
        repeat (3) tick();
        chk("t4_exp_q_empty", exp_q.size(), 32'd0);
`endif

        // 5: reset mid-frame discards the address silently
        send_byte(8'h02);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_state", {29'd0, bus.state_dbg}, {29'd0, ST_IDLE});
        chk("t5_address", {24'd0, bus.request_address}, 32'h00);
        chk("t5_error_code", {29'd0, bus.error_code}, {29'd0, ERR_NONE});
        send_byte(8'h06);
        repeat (3) tick();
        chk("t5_no_valid", {31'd0, bus.request_valid}, 32'd0);
        chk("t5_state_wait", {29'd0, bus.state_dbg}, {29'd0, ST_WAIT_CMD});
        exp_q.push_back({8'h06, 8'h01});
        send_byte(8'h01);
        repeat (3) tick();
        chk("t5_exp_q_empty", exp_q.size(), 32'd0);

        // 6: two frames on consecutive byte slots
        exp_q.push_back({8'h00, 8'h00});
        exp_q.push_back({8'h1F, 8'h06});
        send_byte(8'h00); repeat (3) tick();
        send_byte(8'h00); repeat (3) tick();
        send_byte(8'h1F); repeat (3) tick();
        send_byte(8'h06); repeat (3) tick();
        chk("t6_exp_q_empty", exp_q.size(), 32'd0);
        chk("t6_error_code", {29'd0, bus.error_code}, {29'd0, ERR_NONE});

        repeat (2) tick();
        chk("final_exp_q", exp_q.size(), 32'd0);
        chk("final_err_q", err_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Time limit
    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: observed timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_command_decoder.md
Name: uart_command_decoder

Overview:
- Sits directly downstream of the UART receiver.
- Consumes its one-cycle `has_data` strobe and `data_received` byte, and assembles 2-byte request frames: byte 0 is the sensor address, byte 1 is the command code.
- Validates each frame and presents it to the sensor controller over a valid/ready handshake.
- Reports malformed, overrun or stalled frames on a one-cycle error strobe with a code.

Parameters:
- NUM_SENSORS, 32, number of addressable sensors; an address byte >= NUM_SENSORS is invalid.
- TIMEOUT_CYCLES, 5_000_000, maximum clock cycles allowed between byte 0 and byte 1 (100 ms at 50 MHz); only used with the optional feature.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- has_data  in  1  one-cycle strobe from the UART receiver: `data_received` is valid this cycle.
- data_received  in  8  received byte.
- request_valid  out  1  frame available on `request_address`/`request_command`.
- request_ready  in  1  consumer accepts the frame when high together with `request_valid`.
- request_address  out  8  validated sensor address.
- request_command  out  8  validated command code.
- frame_error  out  1  one-cycle error strobe.
- error_code  out  3  error cause; held until the next error or reset.

Behaviour:
- Reset:
  - state = IDLE.
  - `request_valid`, `frame_error` = 0.
  - `request_address`, `request_command` = 0x00.
  - `error_code` = NONE (0); timer cleared.
  - A reset asserted mid-frame or while holding a request discards that frame silently, with no error strobe.
- States:
  - IDLE: on `has_data`, latch the byte as the address and go to WAIT_CMD.
  - WAIT_CMD: on `has_data`, latch the byte as the command and go to CHECK.
  - CHECK (exactly one cycle): validate the frame.
    - Address >= NUM_SENSORS: go to ERROR with BAD_ADDR (1).
    - Otherwise command > 0x06: go to ERROR with BAD_CMD (2).
    - Otherwise go to HOLD. BAD_ADDR has priority when both are wrong.
  - HOLD: `request_valid` = 1 and the outputs are stable.
    - Leave to IDLE on the cycle where `request_valid` and `request_ready` are both high.
    - `request_valid` drops the following cycle.
  - ERROR (one cycle): `frame_error` = 1, `error_code` updated, then go to IDLE.
- Latency: a command byte strobed at cycle N gives `request_valid` high at N+2. If `request_ready` is already high, the handshake completes at N+2 and the block is back in IDLE at N+3.
- Overrun:
  - A `has_data` in CHECK, HOLD or ERROR drops the byte.
  - It pulses `frame_error` for one cycle with OVERRUN (4) and does not change state or request outputs.
  - If this coincides with the ERROR-state strobe, OVERRUN wins the code; there is still a single strobe.
- A `has_data` arriving in IDLE during the cycle HOLD exits is impossible by construction: the exit and the IDLE byte are in different cycles. A byte arriving in the HOLD-exit cycle counts as an overrun.
- Command codes 0x00–0x06 are valid: STATUS, TEMPERATURE, HUMIDITY, CONT_TEMP_ON, CONT_HUM_ON, CONT_TEMP_OFF, CONT_HUM_OFF.

Optional Feature:
- Macro: UART_CMD_TIMEOUT_EN.
- Defined:
  - A 23-bit timer clears on entry to WAIT_CMD and increments each cycle while in WAIT_CMD.
  - At TIMEOUT_CYCLES-1 with no `has_data`, go to ERROR with TIMEOUT (3) and discard the address.
  - If `has_data` coincides with expiry, the byte wins and the frame proceeds.
- Undefined: no timer logic; WAIT_CMD waits indefinitely and code 3 is never produced.

Decomposition:
- Package `uart_cmd_pkg` holds:
  - state encoding (IDLE, WAIT_CMD, CHECK, HOLD, ERROR);
  - command code constants 0x00–0x06 and CMD_MAX = 0x06;
  - error code constants NONE=0, BAD_ADDR=1, BAD_CMD=2, TIMEOUT=3, OVERRUN=4.
- One sub-module, `inter_byte_timer`:
  - inputs: clear, enable;
  - output: expired;
  - parameter: TIMEOUT_CYCLES;
  - instantiated only under UART_CMD_TIMEOUT_EN.

Test Plan:
1. Strobe 0x05 then 0x01 with `request_ready`=1 → `request_valid` high exactly 2 cycles after the second strobe; `request_address`=0x05, `request_command`=0x01; no `frame_error`.
2. Strobe 0x03, 0x02 with `request_ready`=0 for 10 cycles, then 1 → `request_valid` held 11 cycles with stable outputs and drops the cycle after the handshake. A third byte strobed at cycle 5 of the wait → one `frame_error` pulse with `error_code`=4; request unchanged.
3. Strobe 0x20 (=NUM_SENSORS), 0x09 → no `request_valid`; `frame_error` pulse with `error_code`=1. Then 0x01, 0x07 → `error_code`=2.
4. Timeout (with UART_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=100): strobe 0x04, then nothing → `frame_error` with `error_code`=3 at the 100th cycle after entering WAIT_CMD. Next 0x04, 0x00 → valid request.
5. Reset mid-frame: strobe 0x02, assert `reset` 1 cycle, then strobe 0x06 → 0x06 is treated as an address (no request is issued). Then 0x01 → request address 0x06, command 0x01.
6. Back-to-back: frames (0x00, 0x00) and (0x1F, 0x06) on consecutive UART byte slots → two requests delivered in order, no errors.
